// File: rtl/gam_two_winner_search_pkg.sv
// Shared types and defaults for the GAM nearest-two-node search engine.
package gam_two_winner_search_pkg;

    localparam int GAM_DIM     = 8;
    localparam int GAM_ELEM_W  = 8;
    localparam int GAM_NODE_AW = 6;
    localparam int GAM_CLASS_W = 4;
    localparam int GAM_ED_W    = 2*GAM_ELEM_W + $clog2(GAM_DIM);

    typedef logic [GAM_ELEM_W-1:0]              gam_elem_t;
    typedef gam_elem_t [GAM_DIM-1:0]            gam_vec_t;
    typedef logic [GAM_ED_W-1:0]                gam_ed_t;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} gam_search_state_t;

endpackage

// File: rtl/gam_two_winner_search_sq_dist_unit.sv
// Registered squared-Euclidean distance: per-lane |a-b|^2, summed, one cycle latency.
module sq_dist_unit #(
    parameter int DIM    = 8,
    parameter int ELEM_W = 8,
    parameter int ED_W   = 2*ELEM_W + $clog2(DIM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DIM*ELEM_W-1:0] a,
    input  logic [DIM*ELEM_W-1:0] b,
    output logic                  out_valid,
    output logic [ED_W-1:0]       out_ed
);

    logic [DIM-1:0][2*ELEM_W-1:0] sq;
    logic [ED_W-1:0]              sum;

    for (genvar g = 0; g < DIM; g++) begin : g_lane
        logic [ELEM_W-1:0] ea, eb, diff;
        assign ea    = a[g*ELEM_W +: ELEM_W];
        assign eb    = b[g*ELEM_W +: ELEM_W];
        assign diff  = (ea > eb) ? (ea - eb) : (eb - ea);
        assign sq[g] = diff * diff;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < DIM; i++)
            sum = sum + ED_W'(sq[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ed    <= '0;
        end else begin
            out_valid <= in_valid && !flush;
            if (in_valid)
                out_ed <= sum;
        end
    end

endmodule

// File: rtl/gam_two_winner_search.sv
// Scans one class of node memory, one node per cycle, and keeps the two nearest nodes to x.
module gam_two_winner_search
    import gam_two_winner_search_pkg::*;
#(
    parameter int    DIM     = GAM_DIM,
    parameter int    ELEM_W  = GAM_ELEM_W,
    parameter int    NODE_AW = GAM_NODE_AW,
    parameter int    CLASS_W = GAM_CLASS_W,
    localparam int   ED_W    = 2*ELEM_W + $clog2(DIM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [DIM*ELEM_W-1:0]      x_i,
    input  logic [CLASS_W-1:0]         class_i,
    input  logic [NODE_AW:0]           node_count_i,
    output logic                       mem_rd_en,
    output logic [CLASS_W+NODE_AW-1:0] mem_addr,
    input  logic [DIM*ELEM_W-1:0]      mem_rd_data,
    output logic                       busy,
    output logic                       done,
    output logic [NODE_AW-1:0]         min1_node,
    output logic [NODE_AW-1:0]         min2_node,
    output logic [ED_W-1:0]            min1_ed,
    output logic [ED_W-1:0]            min2_ed,
    output logic                       min1_valid,
    output logic                       min2_valid,
    output logic                       empty_class
);

    localparam logic [NODE_AW:0] N_MAX = {1'b1, {NODE_AW{1'b0}}};

    gam_search_state_t state, nxt;

    logic [DIM*ELEM_W-1:0] x_q;
    logic [CLASS_W-1:0]    cls_q;
    logic [NODE_AW:0]      n_q, n_clip;
    logic [NODE_AW-1:0]    cnt, idx_d0, idx_d1;
    logic                  accept, last, rd_vld, ed_vld;
    logic [ED_W-1:0]       ed;

    assign n_clip = (node_count_i > N_MAX) ? N_MAX : node_count_i;
    assign accept = (state == IDLE) && start && !abort;
    assign last   = ({1'b0, cnt} == (n_q - 1'b1));
    assign busy   = (state == FETCH) || (state == DRAIN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (accept) nxt = (n_clip == '0) ? DONE : FETCH;
            FETCH: if (abort) nxt = IDLE; else if (last) nxt = DRAIN;
            // the last data beat is still entering the distance register until rd_vld drops
            DRAIN: if (abort) nxt = IDLE; else if (!rd_vld) nxt = DONE;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            cnt       <= '0;
            x_q       <= '0;
            cls_q     <= '0;
            n_q       <= '0;
        end else if (accept) begin
            x_q   <= x_i;
            cls_q <= class_i;
            n_q   <= n_clip;
            cnt   <= '0;
            if (n_clip != '0) begin
                mem_rd_en <= 1'b1;
                mem_addr  <= {class_i, {NODE_AW{1'b0}}};
            end
        end else if (state == FETCH) begin
            if (abort || last) begin
                mem_rd_en <= 1'b0;
            end else begin
                cnt      <= cnt + 1'b1;
                mem_addr <= {cls_q, NODE_AW'(cnt + 1'b1)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            idx_d0 <= '0;
            idx_d1 <= '0;
        end else begin
            rd_vld <= mem_rd_en && !abort;
            idx_d0 <= mem_addr[NODE_AW-1:0];
            idx_d1 <= idx_d0;
        end
    end

    sq_dist_unit #(.DIM(DIM), .ELEM_W(ELEM_W), .ED_W(ED_W)) u_sq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_valid  (rd_vld),
        .a         (x_q),
        .b         (mem_rd_data),
        .out_valid (ed_vld),
        .out_ed    (ed)
    );

    // strict compares: on equal distance the earlier (lower) index keeps its place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min1_node   <= '0;
            min2_node   <= '0;
            min1_ed     <= '1;
            min2_ed     <= '1;
            min1_valid  <= 1'b0;
            min2_valid  <= 1'b0;
            empty_class <= 1'b0;
        end else if (accept) begin
            min1_ed     <= '1;
            min2_ed     <= '1;
            min1_valid  <= 1'b0;
            min2_valid  <= 1'b0;
            empty_class <= (n_clip == '0);
        end else if (abort && state != IDLE) begin
            min1_valid <= 1'b0;
            min2_valid <= 1'b0;
        end else if (ed_vld) begin
            if (ed < min1_ed) begin
                min2_node  <= min1_node;
                min2_ed    <= min1_ed;
                min2_valid <= min1_valid;
                min1_node  <= idx_d1;
                min1_ed    <= ed;
                min1_valid <= 1'b1;
            end else if (ed < min2_ed) begin
                min2_node  <= idx_d1;
                min2_ed    <= ed;
                min2_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gam_two_winner_search.sv
// Directed-vector bench for gam_two_winner_search with a one-cycle-latency node memory model.
module tb_gam_two_winner_search;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [63:0] x_i;
    logic [3:0]  class_i;
    logic [6:0]  node_count_i;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [63:0] mem_rd_data = '0;
    logic        busy, done;
    logic [5:0]  min1_node, min2_node;
    logic [18:0] min1_ed, min2_ed;
    logic        min1_valid, min2_valid, empty_class;

    logic [63:0] mem [1024];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cyc, rd_cnt, busy_cnt;
    bit          addr_ok;

    gam_two_winner_search dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_i(x_i), .class_i(class_i), .node_count_i(node_count_i),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .busy(busy), .done(done),
        .min1_node(min1_node), .min2_node(min2_node),
        .min1_ed(min1_ed), .min2_ed(min2_ed),
        .min1_valid(min1_valid), .min2_valid(min2_valid),
        .empty_class(empty_class)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [3:0] cls, input int n, input logic [7:0] v);
        mem[{cls, n[5:0]}] = {8{v}};
    endtask

    // Start at the next posedge (cycle 0 = acceptance), then watch cycles 1.. at negedges.
    task automatic run(input logic [7:0] xe, input logic [3:0] cls, input logic [6:0] cnt,
                       input int abort_at, input int pulse_at,
                       output int dcyc, output int rcnt, output bit aok, output int bcnt);
        x_i = {8{xe}}; class_i = cls; node_count_i = cnt; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        dcyc = -1; rcnt = 0; aok = 1'b1; bcnt = 0;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            abort = (c == abort_at);
            start = (c == pulse_at);
            if (mem_rd_en) begin
                if (mem_addr != {cls, rcnt[5:0]}) aok = 1'b0;
                rcnt++;
            end
            if (busy) bcnt++;
            if (done) begin dcyc = c; break; end
            if (abort_at > 0 && c == abort_at + 3) break;
        end
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        fill(4'd3, 0, 8'd5); fill(4'd3, 1, 8'd1); fill(4'd3, 2, 8'd3); fill(4'd3, 3, 8'd2);
        fill(4'd5, 0, 8'd2); fill(4'd5, 1, 8'd2); fill(4'd5, 2, 8'd1);
        fill(4'd2, 0, 8'd13);
        for (int i = 0; i < 63; i++) fill(4'd7, i, 8'd255);
        fill(4'd7, 63, 8'd254);
        for (int i = 0; i < 10; i++) fill(4'd8, i, 8'(9 - i));

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        x_i = '0; class_i = '0; node_count_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done",    done, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_rd_en",   mem_rd_en, 0);
        chk("rst_min1_ed", min1_ed, 32'h7FFFF);
        chk("rst_min2_ed", min2_ed, 32'h7FFFF);
        chk("rst_valid",   {min1_valid, min2_valid}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic: distances {200,8,72,32}; start pulsed in DONE must be ignored
        run(8'd0, 4'd3, 7'd4, 0, 7, done_cyc, rd_cnt, addr_ok, busy_cnt);
        chk("a_done_cyc", done_cyc, 7);
        chk("a_rd_cnt",   rd_cnt, 4);
        chk("a_addr",     addr_ok, 1);
        chk("a_busy_cnt", busy_cnt, 6);
        chk("a_min1",     {min1_node, min1_ed}, {6'd1, 19'd8});
        chk("a_min2",     {min2_node, min2_ed}, {6'd3, 19'd32});
        chk("a_valid",    {min1_valid, min2_valid, empty_class}, 3'b110);
        @(negedge clk);
        chk("a_start_in_done_ignored", busy, 0);

        // tie: {32,32,8}
        run(8'd0, 4'd5, 7'd3, 0, 0, done_cyc, rd_cnt, addr_ok, busy_cnt);
        chk("tie_done_cyc", done_cyc, 6);
        chk("tie_min1",     {min1_node, min1_ed}, {6'd2, 19'd8});
        chk("tie_min2",     {min2_node, min2_ed}, {6'd0, 19'd32});

        // empty class
        run(8'd0, 4'd1, 7'd0, 0, 0, done_cyc, rd_cnt, addr_ok, busy_cnt);
        chk("empty_done_cyc", done_cyc, 1);
        chk("empty_rd_cnt",   rd_cnt, 0);
        chk("empty_busy",     busy_cnt, 0);
        chk("empty_flags",    {min1_valid, min2_valid, empty_class}, 3'b001);

        // single node: 8*3^2 = 72
        run(8'd10, 4'd2, 7'd1, 0, 0, done_cyc, rd_cnt, addr_ok, busy_cnt);
        chk("one_done_cyc", done_cyc, 4);
        chk("one_min1_ed",  min1_ed, 72);
        chk("one_valid",    {min1_valid, min2_valid}, 2'b10);
        chk("one_min2_ed",  min2_ed, 32'h7FFFF);

        // max values, count 65 clipped to 64
        run(8'd0, 4'd7, 7'd65, 0, 0, done_cyc, rd_cnt, addr_ok, busy_cnt);
        chk("max_done_cyc", done_cyc, 67);
        chk("max_rd_cnt",   rd_cnt, 64);
        chk("max_addr",     addr_ok, 1);
        chk("max_min1",     {min1_node, min1_ed}, {6'd63, 19'd516128});
        chk("max_min2",     {min2_node, min2_ed}, {6'd0, 19'd520200});

        // abort in cycle 3 of N=10
        run(8'd0, 4'd8, 7'd10, 3, 0, done_cyc, rd_cnt, addr_ok, busy_cnt);
        chk("abort_no_done", done_cyc, 32'hFFFFFFFF);
        chk("abort_rd_cnt",  rd_cnt, 3);
        chk("abort_busy",    busy_cnt, 3);
        chk("abort_valid",   {min1_valid, min2_valid}, 0);

        // restart after abort; start pulsed while busy is ignored
        run(8'd0, 4'd8, 7'd10, 0, 4, done_cyc, rd_cnt, addr_ok, busy_cnt);
        chk("re_done_cyc", done_cyc, 13);
        chk("re_rd_cnt",   rd_cnt, 10);
        chk("re_addr",     addr_ok, 1);
        chk("re_min1",     {min1_node, min1_ed}, {6'd9, 19'd0});
        chk("re_min2",     {min2_node, min2_ed}, {6'd8, 19'd8});
        chk("re_valid",    {min1_valid, min2_valid}, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
